// File: rtl/multi_cycle_ctrl_pkg.sv
// ============================================================================
// Module  : cpu_defs (package)
// Purpose : State encoding, instruction-class encoding and class decode
//           shared by the multi-cycle MIPS control FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

   localparam int c_STATE_W = 3;

   // Display-visible encoding; codes 6 and 7 are unused and recover to IDLE.
   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EXE  = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP   = 3'd0,
      CLS_JBR   = 3'd1,
      CLS_LOAD  = 3'd2,
      CLS_STORE = 3'd3,
      CLS_WB    = 3'd4
   } cls_t;

   // Resolves overlapping decoder bits: jbr > load > store > wb > nop.
   function automatic cls_t decode_class(input logic jbr,
                                         input logic load,
                                         input logic store,
                                         input logic wb);
      cls_t c;
      if (jbr)
         c = CLS_JBR;
      else if (load)
         c = CLS_LOAD;
      else if (store)
         c = CLS_STORE;
      else if (wb)
         c = CLS_WB;
      else
         c = CLS_NOP;
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module  : multi_cycle_ctrl
// Purpose : Main control FSM of the multi-cycle MIPS datapath: sequences
//           IF/ID/EXE/MEM/WB, handshakes with stalling memories, supports
//           free-run / single-step and counts retired instructions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_ctrl
   import cpu_defs::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 run,
   input  logic                 step,
   input  logic                 is_jbr,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic                 is_wb,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   output logic                 ir_wen,
   output logic                 ab_wen,
   output logic                 alu_out_wen,
   output logic                 mdr_wen,
   output logic                 rf_wen,
   output logic                 pc_wen,
   output logic                 inst_retire,
   output logic [CNT_W-1:0]     retire_cnt,
   output logic [c_STATE_W-1:0] state,
   output logic                 halted
);

   state_t           r_state;
   state_t           w_state_nxt;
   cls_t             r_cls;
   cls_t             w_cls_id;
   logic             w_retire;
   logic [CNT_W-1:0] r_retire_cnt;

   assign w_cls_id = decode_class(is_jbr, is_load, is_store, is_wb);

   // ------------------------------------------------------------------------
   // State, latched class and retire counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_cls        <= CLS_NOP;
         r_retire_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_ID)
            r_cls <= w_cls_id;
         if (w_retire)
            r_retire_cnt <= r_retire_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and per-cycle datapath enables
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      imem_req    = 1'b0;
      ir_wen      = 1'b0;
      ab_wen      = 1'b0;
      alu_out_wen = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      mdr_wen     = 1'b0;
      rf_wen      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (run || step)
               w_state_nxt = ST_IF;
         end

         ST_IF: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_wen      = 1'b1;
               w_state_nxt = ST_ID;
            end
         end

         // Class is taken from the live decoder here; later states use r_cls.
         ST_ID: begin
            ab_wen = 1'b1;
            if (w_cls_id == CLS_JBR)
               w_retire = 1'b1;
            else
               w_state_nxt = ST_EXE;
         end

         ST_EXE: begin
            alu_out_wen = 1'b1;
            case (r_cls)
               CLS_LOAD,
               CLS_STORE: w_state_nxt = ST_MEM;
               CLS_WB:    w_state_nxt = ST_WB;
               default:   w_retire    = 1'b1;
            endcase
         end

         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (r_cls == CLS_STORE);
            if (dmem_ack) begin
               if (r_cls == CLS_STORE) begin
                  w_retire = 1'b1;
               end else begin
                  mdr_wen     = 1'b1;
                  w_state_nxt = ST_WB;
               end
            end
         end

         ST_WB: begin
            rf_wen   = 1'b1;
            w_retire = 1'b1;
         end

         default: w_state_nxt = ST_IDLE;
      endcase

      // Instruction boundary: continue only while run is held.
      if (w_retire)
         w_state_nxt = run ? ST_IF : ST_IDLE;
   end

   assign pc_wen      = w_retire;
   assign inst_retire = w_retire;
   assign retire_cnt  = r_retire_cnt;
   assign state       = r_state;
   assign halted      = (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. It runs each instruction through IF/ID/EXE/MEM/WB over several clocks and issues per-cycle register write-enables to the datapath. It handshakes with the instruction and data memories, which may stall. It also supports free-run and single-step operation for the display board, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
run  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
step  in  1  one-cycle pulse; executes exactly one instruction, honoured only in IDLE.
is_jbr  in  1  decoded class: jump/branch, resolved in ID.
is_load  in  1  decoded class: LW.
is_store  in  1  decoded class: SW.
is_wb  in  1  decoded: writes the register file (ALU, LUI, ADDIU, LW).
imem_req  out  1  instruction fetch request.
imem_ack  in  1  fetch data valid this cycle.
dmem_req  out  1  data memory request.
dmem_we  out  1  data memory write qualifier, valid with dmem_req.
dmem_ack  in  1  data access complete this cycle.
ir_wen  out  1  latch instruction register.
ab_wen  out  1  latch rs/rt operand registers.
alu_out_wen  out  1  latch ALU result register.
mdr_wen  out  1  latch memory data register.
rf_wen  out  1  register file write.
pc_wen  out  1  update PC from datapath next_pc.
inst_retire  out  1  one-cycle pulse per completed instruction.
retire_cnt  out  CNT_W  retired-instruction count.
state  out  3  current state, for display.
halted  out  1  1 when state == IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; retire_cnt=0; latched class flags=0.
  - All enables, requests and inst_retire drop to 0 immediately, without waiting for a clock edge.
- State encoding: IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5. Codes 6/7 go to IDLE on the next clock.
- IDLE:
  - If run=1 or step=1, go to IF. Otherwise stay in IDLE.
- IF:
  - imem_req=1.
  - On imem_ack: ir_wen=1, go to ID. Otherwise hold IF.
- ID:
  - ab_wen=1; class flags are latched into internal registers.
  - Class priority: jbr > load > store > wb > nop.
  - If is_jbr: retire here, with no alu_out_wen and no rf_wen. Otherwise go to EXE.
- EXE:
  - alu_out_wen=1.
  - load or store: go to MEM. wb: go to WB. nop (no class bit set): retire here.
- MEM:
  - dmem_req=1; dmem_we=1 for store, 0 for load.
  - Hold until dmem_ack.
  - On ack, store: retire.
  - On ack, load: mdr_wen=1, go to WB.
- WB:
  - rf_wen=1 and retire, in the same cycle.
- Retire cycle:
  - pc_wen=1 and inst_retire=1; retire_cnt increments on that clock edge, wrapping to 0.
  - Next state is IF if run=1, otherwise IDLE.
- Outputs are combinational from state, the latched class flags and the acks. No output asserts in IDLE.
- Latency with zero-wait acks:
  - jbr: 2 cycles.
  - nop: 3 cycles.
  - ALU: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - Each wait cycle on an ack adds one cycle.
- Boundary conditions:
  - imem_ack outside IF and dmem_ack outside MEM are ignored.
  - run falling mid-instruction: the current instruction completes, then the FSM stops in IDLE.
  - step outside IDLE is ignored.
  - run=1 and step=1 together in IDLE behave as run.
  - Class inputs changing after ID have no effect.
  - Reset asserted mid-MEM: dmem_req drops asynchronously and no retire occurs.

Decomposition:
- Shared package (cpu_defs): state encoding constants and the state width (3).
- Single module; no sub-module required.

Test Plan:
- Reset in MEM: assert resetn=0 while dmem_req=1 -> dmem_req=0 before the next edge; state=0, retire_cnt=0, halted=1.
- ALU free-run: run=1, is_wb=1, acks tied high -> inst_retire every 4th cycle with rf_wen and pc_wen in that cycle; retire_cnt=3 after 12 cycles.
- Load with stall: is_load=1, dmem_ack 3 cycles after request -> dmem_req high 4 cycles, dmem_we=0, mdr_wen on the ack cycle, rf_wen next cycle; 8 cycles total.
- Branch: is_jbr=1 -> retire in ID, 2 cycles per instruction; alu_out_wen, dmem_req and rf_wen never assert.
- Single step: run=0, one step pulse -> exactly one inst_retire, then halted=1; a second step issued mid-instruction is ignored (retire_cnt=1).
- Counter wrap: CNT_W=4, 16 retirements -> retire_cnt=0; store with dmem_ack held high -> dmem_we=1 and retire in the MEM cycle.
